// File: rtl/sprite_rom_arbiter.sv
// ---------------------------------------------------------------------------
// Module   : sprite_rom_arbiter
// Function : Round-robin share of one sprite-index ROM and palette between
//            NUM_REQ requesters; responses carry the owner id, in grant order.
// Option   : SPRITE_ARB_COLORKEY_EN makes KEY_INDEX pixels transparent.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module sprite_rom_arbiter #(
  parameter int         NUM_REQ   = 4,
  parameter int         ADDR_W    = 12,
  parameter int         ROM_LAT   = 2,
  parameter logic [7:0] KEY_INDEX = 8'h00
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       rom_en,
  output logic [ADDR_W-1:0]          rom_addr,
  input  logic [7:0]                 rom_index,
  output logic [7:0]                 pal_index,
  input  logic [11:0]                pal_rgb,
  output logic                       rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [11:0]                rsp_rgb,
  output logic                       rsp_opaque,
  output logic                       busy
);

  localparam int              ID_W   = $clog2(NUM_REQ);
  localparam logic [ID_W-1:0] c_last = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0]   r_ptr;
  logic [ROM_LAT:0]  r_tag_v;
  logic [ID_W-1:0]   r_tag_id [ROM_LAT+1];

  logic              w_gnt;
  logic [ID_W-1:0]   w_gnt_id;
  logic [ID_W-1:0]   w_ptr_nxt;
  logic [ADDR_W-1:0] w_gnt_addr;

  // First valid requester at or above the pointer, wrapping around.
  always_comb begin
    w_gnt    = 1'b0;
    w_gnt_id = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_gnt && req_valid[(int'(r_ptr) + k) % NUM_REQ]) begin
        w_gnt    = 1'b1;
        w_gnt_id = ID_W'((int'(r_ptr) + k) % NUM_REQ);
      end
    end
  end

  assign req_ready  = w_gnt ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << w_gnt_id) : '0;
  assign w_ptr_nxt  = (w_gnt_id == c_last) ? '0 : w_gnt_id + ID_W'(1);
  assign w_gnt_addr = req_addr[w_gnt_id*ADDR_W +: ADDR_W];
  assign pal_index  = rom_index;
  assign busy       = (|req_valid) | (|r_tag_v) | rom_en;

`ifndef SPRITE_ARB_COLORKEY_EN
  logic w_unused_key;
  assign w_unused_key = ^KEY_INDEX;
`endif

  // Tag slot 0 is loaded alongside rom_en; slot ROM_LAT lines up with rom_index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr      <= '0;
      rom_en     <= 1'b0;
      rom_addr   <= '0;
      r_tag_v    <= '0;
      for (int k = 0; k <= ROM_LAT; k++) r_tag_id[k] <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_rgb    <= '0;
      rsp_opaque <= 1'b0;
    end else begin
      rom_en <= w_gnt;
      if (w_gnt) begin
        r_ptr    <= w_ptr_nxt;
        rom_addr <= w_gnt_addr;
      end
      r_tag_v     <= {r_tag_v[ROM_LAT-1:0], w_gnt};
      r_tag_id[0] <= w_gnt_id;
      for (int k = 1; k <= ROM_LAT; k++) r_tag_id[k] <= r_tag_id[k-1];
      rsp_valid <= r_tag_v[ROM_LAT];
      if (r_tag_v[ROM_LAT]) begin
        rsp_id <= r_tag_id[ROM_LAT];
`ifdef SPRITE_ARB_COLORKEY_EN
        if (rom_index == KEY_INDEX) begin
          rsp_opaque <= 1'b0;
          rsp_rgb    <= 12'h000;
        end else begin
          rsp_opaque <= 1'b1;
          rsp_rgb    <= pal_rgb;
        end
`else
        rsp_opaque <= 1'b1;
        rsp_rgb    <= pal_rgb;
`endif
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sprite_rom_arbiter.sv
// ---------------------------------------------------------------------------
// Module   : tb_sprite_rom_arbiter
// Function : Self-checking bench for sprite_rom_arbiter with ROM and palette
//            models and a response scoreboard.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sprite_rom_arbiter;

  localparam int         NUM_REQ   = 4;
  localparam int         ADDR_W    = 12;
  localparam int         ROM_LAT   = 2;
  localparam int         ID_W      = 2;
  localparam logic [7:0] KEY_INDEX = 8'h00;

  logic                      clk;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      rom_en;
  logic [ADDR_W-1:0]         rom_addr;
  logic [7:0]                rom_index;
  logic [7:0]                pal_index;
  logic [11:0]               pal_rgb;
  logic                      rsp_valid;
  logic [ID_W-1:0]           rsp_id;
  logic [11:0]               rsp_rgb;
  logic                      rsp_opaque;
  logic                      busy;

  sprite_rom_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ADDR_W   (ADDR_W),
    .ROM_LAT  (ROM_LAT),
    .KEY_INDEX(KEY_INDEX)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .rom_index (rom_index),
    .pal_index (pal_index),
    .pal_rgb   (pal_rgb),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_rgb   (rsp_rgb),
    .rsp_opaque(rsp_opaque),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] romf(input logic [ADDR_W-1:0] a);
    return a[7:0] - 8'h06 + {a[11:8], 4'h0};
  endfunction

  function automatic logic [11:0] palf(input logic [7:0] i);
    return {i[3:0] ^ 4'h3, ~i[7:4], i[7:4] + i[3:0]};
  endfunction

  function automatic logic exp_opq(input logic [7:0] i);
`ifdef SPRITE_ARB_COLORKEY_EN
    return i != KEY_INDEX;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [11:0] exp_rgb(input logic [7:0] i);
    return exp_opq(i) ? palf(i) : 12'h000;
  endfunction

  // ROM: ROM_LAT registers from rom_addr to rom_index; palette is combinational.
  logic [7:0] rom_pipe [ROM_LAT];
  always @(posedge clk) begin
    rom_pipe[0] <= romf(rom_addr);
    for (int k = 1; k < ROM_LAT; k++) rom_pipe[k] <= rom_pipe[k-1];
  end
  assign rom_index = rom_pipe[ROM_LAT-1];
  assign pal_rgb   = palf(pal_index);

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [ID_W-1:0] id;
    logic [11:0]     rgb;
    logic            opq;
    int              cyc;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] mon_idx;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
    end else begin
      chk("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(mon_e.id));
          chk("rsp_rgb", 32'(rsp_rgb), 32'(mon_e.rgb));
          chk("rsp_opaque", 32'(rsp_opaque), 32'(mon_e.opq));
          chk("rsp_latency", 32'(cyc - mon_e.cyc), 32'(ROM_LAT + 2));
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          mon_idx = romf(req_addr[i*ADDR_W +: ADDR_W]);
          sb.push_back('{ID_W'(i), exp_rgb(mon_idx), exp_opq(mon_idx), cyc});
        end
      end
    end
  end

  typedef struct {
    logic [3:0] valid;
    logic [7:0] base;
    logic [3:0] exp_ready;
  } vec_t;

  vec_t tbl [14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addrs(input logic [7:0] base);
    for (int i = 0; i < NUM_REQ; i++) req_addr[i*ADDR_W +: ADDR_W] = {4'(i), base};
  endtask

  int rsp_cnt;

  initial begin
    tbl[0]  = '{4'b1111, 8'h20, 4'b0001};
    tbl[1]  = '{4'b1111, 8'h31, 4'b0010};
    tbl[2]  = '{4'b1111, 8'h42, 4'b0100};
    tbl[3]  = '{4'b1111, 8'h53, 4'b1000};
    tbl[4]  = '{4'b1010, 8'h64, 4'b0010};
    tbl[5]  = '{4'b1010, 8'h75, 4'b1000};
    tbl[6]  = '{4'b1010, 8'h86, 4'b0010};
    tbl[7]  = '{4'b0000, 8'h97, 4'b0000};
    tbl[8]  = '{4'b0011, 8'hA8, 4'b0001};
    tbl[9]  = '{4'b0001, 8'hB9, 4'b0001};
    tbl[10] = '{4'b1000, 8'hCA, 4'b1000};
    tbl[11] = '{4'b0100, 8'hDB, 4'b0100};
    tbl[12] = '{4'b1010, 8'hEC, 4'b1000};
    tbl[13] = '{4'b1000, 8'hFD, 4'b1000};

    // Reset with requests pending.
    reset     = 1'b1;
    req_valid = 4'b0110;
    set_addrs(8'h18);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rom_en", 32'(rom_en), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_rgb", 32'(rsp_rgb), 32'd0);
    chk("rst_rsp_opaque", 32'(rsp_opaque), 32'd0);
    chk("rst_ready_ptr0", 32'(req_ready), 32'b0010);
    chk("rst_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("first_grant_lowest", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    repeat (ROM_LAT + 3) tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // Single read from requester 0; pointer is at 2 so the search wraps.
    req_addr[0 +: ADDR_W] = 12'h010;
    req_valid = 4'b0001;
    #1;
    chk("single_ready", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    chk("single_rom_en", 32'(rom_en), 32'd1);
    chk("single_rom_addr", 32'(rom_addr), 32'h010);
    chk("single_busy", 32'(busy), 32'd1);
    repeat (ROM_LAT) tick();
    chk("single_pal_index", 32'(pal_index), 32'h0A);
    tick();
    chk("single_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("single_rsp_id", 32'(rsp_id), 32'd0);
    chk("single_rsp_rgb", 32'(rsp_rgb), 32'(palf(8'h0A)));
    tick();
    chk("single_rsp_pulse", 32'(rsp_valid), 32'd0);
    chk("single_rgb_hold", 32'(rsp_rgb), 32'(palf(8'h0A)));
    chk("single_rom_en_low", 32'(rom_en), 32'd0);

    // Return pointer to 0, then run the arbitration table back to back.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int e = 0; e < 14; e++) begin
      req_valid = tbl[e].valid;
      set_addrs(tbl[e].base);
      #1;
      chk($sformatf("tbl_ready_%0d", e), 32'(req_ready), 32'(tbl[e].exp_ready));
      tick();
    end
    req_valid = '0;
    repeat (ROM_LAT + 4) tick();
    chk("tbl_drained", 32'(sb.size()), 32'd0);

    // Three reads in flight, then reset: none of them may respond.
    req_valid = 4'b1111;
    set_addrs(8'h44);
    repeat (3) tick();
    req_valid = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("post_rst_rom_en", 32'(rom_en), 32'd0);
    rsp_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (rsp_valid) rsp_cnt++;
    end
    chk("no_rsp_after_reset", 32'(rsp_cnt), 32'd0);

    // Fresh read after reset hitting palette index 0.
    req_addr[2*ADDR_W +: ADDR_W] = 12'h006;
    req_valid = 4'b0100;
    #1;
    chk("key_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    repeat (ROM_LAT) tick();
    chk("key_pal_index", 32'(pal_index), 32'h00);
    tick();
    chk("key_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("key_rsp_id", 32'(rsp_id), 32'd2);
    chk("key_rsp_opaque", 32'(rsp_opaque), 32'(exp_opq(8'h00)));
    chk("key_rsp_rgb", 32'(rsp_rgb), 32'(exp_rgb(8'h00)));

    for (int k = 0; k < 50 && sb.size() != 0; k++) tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares one sprite-index ROM (COE-initialised BRAM) and one sprite palette lookup between NUM_REQ sprite requesters (e.g. several butterfly instances on screen).
- Grants one request per cycle, round-robin. Issues the ROM read and waits a fixed ROM latency. Drives the returned 8-bit index into the palette. Returns the 12-bit RGB tagged with the requester id.
- Sits between the per-sprite draw logic and the ROM/palette pair, upstream of the VGA colour mapper.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 12, sprite ROM address width.
- ROM_LAT, 2, ROM read latency in clocks, from rom_en to valid rom_index (1..4).
- KEY_INDEX, 8'h00, palette index treated as transparent (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester read request.
- req_addr  in  NUM_REQ*ADDR_W  per-requester ROM address; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_ready  out  NUM_REQ  one-hot grant; handshake completes when valid&ready.
- rom_en  out  1  ROM read enable (registered).
- rom_addr  out  ADDR_W  ROM address (registered).
- rom_index  in  8  ROM data, valid ROM_LAT cycles after rom_en.
- pal_index  out  8  palette index, combinational copy of rom_index.
- pal_rgb  in  12  palette output {red,green,blue}, combinational from pal_index.
- rsp_valid  out  1  response strobe (registered).
- rsp_id  out  $clog2(NUM_REQ)  requester that owns the response.
- rsp_rgb  out  12  colour.
- rsp_opaque  out  1  0 = transparent pixel.
- busy  out  1  any read in flight or any req_valid high.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: rom_en=0, rom_addr=0, rsp_valid=0, rsp_id=0, rsp_rgb=0, rsp_opaque=0, RR pointer=0, pipeline valid bits all 0.
- Arbitration (combinational):
  - Search starts at the RR pointer and proceeds upward, wrapping modulo NUM_REQ.
  - The first i with req_valid[i]=1 gets req_ready[i]=1; all other ready bits are 0.
  - No valid request: req_ready=0.
- Pointer update: on a grant to i, the pointer becomes (i+1) mod NUM_REQ at the next edge. With no grant, the pointer holds.
- Issue: on a handshake in cycle T, at edge T+1 set rom_en=1, rom_addr=req_addr[i], and push {valid, id=i} into a ROM_LAT+1-deep tag shift register. With no handshake, rom_en=0 and rom_addr holds its previous value.
- Return: rom_index is valid at cycle T+1+ROM_LAT. pal_index=rom_index. The tag reaches the tail of the shift register in that same cycle.
- Capture at edge T+2+ROM_LAT:
  - rsp_valid=1, rsp_id=tag id, rsp_rgb=pal_rgb, rsp_opaque per the optional feature.
- Total latency from handshake to rsp_valid is ROM_LAT+2 cycles. Throughput is 1 per cycle. There is no response backpressure; the consumer must always accept.
- rsp_valid is a single-cycle pulse per read. rsp_rgb and rsp_id hold their previous values when rsp_valid=0.
- Back-to-back grants fully pipeline. Tags never reorder; responses appear in grant order.
- A requester that drops req_valid before it is granted loses nothing, and no read is issued for it.
- Reset mid-operation: all in-flight tags are discarded. No rsp_valid occurs for reads issued before reset. The pointer returns to 0.
- busy = |req_valid OR any tag valid OR rom_en.

Optional Feature:
- Macro: SPRITE_ARB_COLORKEY_EN.
- Defined: when the captured rom_index equals KEY_INDEX, rsp_opaque=0 and rsp_rgb=12'h000. Otherwise rsp_opaque=1 and rsp_rgb=pal_rgb. This requires a registered copy of rom_index aligned with the tag.
- Undefined: rsp_opaque=1 on every response, rsp_rgb=pal_rgb always, and KEY_INDEX is ignored.

Test Plan:
- Reset: assert reset with requests active → all outputs at reset values, req_ready reflects pointer 0. Deassert → first grant goes to the lowest valid requester.
- Single read (ROM_LAT=2): req 0, addr 12'h010, handshake at cycle 5, ROM model returns 8'h0A → rom_en=1 and rom_addr=12'h010 at cycle 6; pal_index=8'h0A at cycle 8; rsp_valid=1 with rsp_id=0 and rsp_rgb equal to palette[10] at cycle 9.
- All four requesters valid continuously → grants 0,1,2,3,0,1… one per cycle; each req_ready is high once per 4 cycles; responses return in the same order with matching ids.
- Only requesters 1 and 3 valid, pointer at 2 → grant 3, then 1, then 3. Requester 1 drops valid before its turn → no read issued for it, and the pointer skips to 3.
- Reset pulsed at cycle 7 with 3 reads in flight → no rsp_valid pulses in the following 10 cycles. A new request after reset completes normally with ROM_LAT+2 latency.
- ROM model returns 8'h00 (KEY_INDEX): with SPRITE_ARB_COLORKEY_EN → rsp_opaque=0 and rsp_rgb=12'h000. Without it → rsp_opaque=1 and rsp_rgb equal to the palette entry for index 0.
